// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/bubble merge, registered flush, stall counter and watchdog
module pipe_stall_ctrl #(
    parameter int                  STAGES    = 6,
    parameter int                  NREQ      = 3,
    parameter logic [NREQ*8-1:0]   REQ_STAGE = {8'd3, 8'd2, 8'd1},
    parameter int                  TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic [31:0]       stall_cnt,
    output logic              stall_timeout
);

    localparam logic [7:0]  LAST_STAGE = 8'(STAGES - 1);
    localparam logic [31:0] RUN_FIRE   = 32'(TIMEOUT - 1);

    logic        req_any;
    logic [7:0]  depth;
    logic [31:0] cnt_q;
    logic [15:0] run_q;

    function automatic logic [7:0] clamp_stage(input logic [7:0] s);
        if ({24'd0, s} >= 32'(STAGES)) begin
            return LAST_STAGE;
        end else begin
            return s;
        end
    endfunction

    // Deepest frozen stage across every active request.
    always_comb begin
        req_any = 1'b0;
        depth   = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (stall_req[i]) begin
                req_any = 1'b1;
                if (clamp_stage(REQ_STAGE[8*i +: 8]) > depth) begin
                    depth = clamp_stage(REQ_STAGE[8*i +: 8]);
                end
            end
        end
    end

    // A pending flush overrides every stall so the redirect is never held off.
    always_comb begin
        stall  = '0;
        bubble = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (req_any && !flush) begin
                stall[k]  = (8'(k) <= depth);
                bubble[k] = (9'(k) == ({1'b0, depth} + 9'd1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush  <= 1'b0;
            new_pc <= 32'h0;
        end else begin
            flush <= flush_req;
            if (flush_req) begin
                new_pc <= flush_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'h0;
        end else if (stall[0] && !flush && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 16'h0;
        end else if (!stall[0]) begin
            run_q <= 16'h0;
        end else if (run_q != 16'hFFFF) begin
            run_q <= run_q + 16'd1;
        end
    end

    // Flush clears the flag and takes priority over a same-edge set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_timeout <= 1'b0;
        end else if (flush) begin
            stall_timeout <= 1'b0;
        end else if ((TIMEOUT != 0) && stall[0] && ({16'd0, run_q} == RUN_FIRE)) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule
